tmds_serializer: RTL

- Parametrised TMDS serializer: accepts one encoded symbol per channel through a valid/ready handshake and shifts it out LSB-first, BITS_PER_CLK bits per clock.
- Generates the TMDS clock-lane pattern in the same clock domain. No pixel clock is forwarded.
- Sits between the TMDS encoders and the output buffers or ODDR primitives.
- Substitutes a control symbol when no data is available (underflow) and flags the event.

---
 rtl/tmds_serializer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tmds_serializer.sv
// -----------------------------------------------------------------------------
// tmds_serializer
//
// Parametrised TMDS serializer. Takes one encoded symbol per data channel
// through a valid/ready handshake and shifts it out LSB-first, BITS_PER_CLK
// bits per clock, together with the TMDS clock-lane pattern. All logic runs in
// the single serial (or half-rate) clock domain; no pixel clock is forwarded.
// When no symbol is offered at a load slot the idle control symbol is sent
// instead and a sticky underflow flag is raised.
//
// Optional feature (compile-time macro TMDS_SER_UNDERFLOW_CNT_EN):
//   adds the 16-bit saturating underflow event counter o_underflow_cnt.
//   With the macro undefined the port and counter are absent.
//
// Parameters:
//   NUM_CH        number of data channels
//   SYM_W         symbol width in bits
//   BITS_PER_CLK  bits emitted per channel per clock (1 = SDR, 2 = DDR);
//                 must divide SYM_W
//   IDLE_SYM      symbol substituted on underflow (control C1C0 = 00)
//
// Ports:
//   i_tmds_clk       serial bit clock (half-rate for DDR); the only clock
//   i_reset          asynchronous, active-high reset
//   i_sym_data       symbol set; channel ch at [ch*SYM_W +: SYM_W]
//   i_sym_valid      symbol set valid
//   o_sym_ready      serializer takes a symbol at the coming edge
//   i_clr_underflow  clears the sticky underflow flag (and counter)
//   o_ser_data       channel ch bits at [ch*BITS_PER_CLK +: BITS_PER_CLK],
//                    bit 0 earlier in time
//   o_clk_lane       clock-lane bits, same ordering
//   o_sym_strobe     high in the first cycle of each emitted symbol
//   o_underflow      sticky underflow flag
//   o_underflow_cnt  saturating underflow count (optional)
// -----------------------------------------------------------------------------
module tmds_serializer #(
  parameter int               NUM_CH       = 3,
  parameter int               SYM_W        = 10,
  parameter int               BITS_PER_CLK = 1,
  parameter logic [SYM_W-1:0] IDLE_SYM     = 10'b1101010100
) (
  input  logic                           i_tmds_clk,
  input  logic                           i_reset,
  input  logic [NUM_CH*SYM_W-1:0]        i_sym_data,
  input  logic                           i_sym_valid,
  output logic                           o_sym_ready,
  input  logic                           i_clr_underflow,
  output logic [NUM_CH*BITS_PER_CLK-1:0] o_ser_data,
  output logic [BITS_PER_CLK-1:0]        o_clk_lane,
  output logic                           o_sym_strobe,
  output logic                           o_underflow
`ifdef TMDS_SER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]                    o_underflow_cnt
`endif
);

  // Number of clock slots per symbol and the slot-counter geometry.
  localparam int N     = SYM_W / BITS_PER_CLK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Clock-lane symbol: lower half ones, upper half zeros (10'b0000011111).
  localparam logic [SYM_W-1:0] CLK_PAT = {SYM_W{1'b1}} >> (SYM_W - SYM_W / 2);

  // A width that does not split evenly into slots cannot be serialized.
  if ((SYM_W % BITS_PER_CLK) != 0) begin : g_bad_cfg
    $error("tmds_serializer: BITS_PER_CLK must divide SYM_W");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ready_q;
  logic             strobe_q;
  logic             underflow_q;
  logic [SYM_W-1:0] lane_sr;
  logic [SYM_W-1:0] ch_sr [NUM_CH];

  // The load slot is exactly the cycle in which ready is presented, so the
  // registered ready doubles as the load enable and the handshake is exact.
  logic load;
  logic uf_event;

  assign load     = ready_q;
  assign uf_event = ready_q & ~i_sym_valid;

  // Free-running slot counter, wrapping N-1 -> 0.
  assign cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Slot counter, handshake and strobe
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge i_tmds_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt      <= '0;
      ready_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      // Registered look-ahead: ready is high while cnt sits at N-1.
      ready_q  <= (cnt_nxt == LAST);
      // First cycle of a freshly loaded symbol.
      strobe_q <= load;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift registers (data channels and clock lane)
  // ---------------------------------------------------------------------------
  // NOTE: these shift registers are reset even though they are array-like,
  // because their low bits drive the outputs directly and a partly shifted
  // symbol must be discarded on reset; pure storage arrays would not need it.
  always_ff @(posedge i_tmds_clk or posedge i_reset) begin
    if (i_reset) begin
      lane_sr <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        ch_sr[ch] <= '0;
      end
    end else if (load) begin
      lane_sr <= CLK_PAT;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        ch_sr[ch] <= i_sym_valid ? i_sym_data[ch*SYM_W +: SYM_W] : IDLE_SYM;
      end
    end else begin
      // Zero-filled right shift: the low bits are always the next to emit.
      lane_sr <= lane_sr >> BITS_PER_CLK;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        ch_sr[ch] <= ch_sr[ch] >> BITS_PER_CLK;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky underflow flag: a new event outranks a simultaneous clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_tmds_clk or posedge i_reset) begin
    if (i_reset) begin
      underflow_q <= 1'b0;
    end else if (uf_event) begin
      underflow_q <= 1'b1;
    end else if (i_clr_underflow) begin
      underflow_q <= 1'b0;
    end
  end

`ifdef TMDS_SER_UNDERFLOW_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating underflow counter; clear plus event in one cycle yields 1.
  // ---------------------------------------------------------------------------
  logic [15:0] uf_cnt_q;

  always_ff @(posedge i_tmds_clk or posedge i_reset) begin
    if (i_reset) begin
      uf_cnt_q <= '0;
    end else if (i_clr_underflow) begin
      uf_cnt_q <= uf_event ? 16'd1 : 16'd0;
    end else if (uf_event && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_q <= uf_cnt_q + 16'd1;
    end
  end

  assign o_underflow_cnt = uf_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: straight from flops, no combinational path from any input.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    o_ser_data = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      o_ser_data[ch*BITS_PER_CLK +: BITS_PER_CLK] = ch_sr[ch][BITS_PER_CLK-1:0];
    end
  end

  assign o_clk_lane   = lane_sr[BITS_PER_CLK-1:0];
  assign o_sym_ready  = ready_q;
  assign o_sym_strobe = strobe_q;
  assign o_underflow  = underflow_q;

endmodule
